// File: rtl/decode_stage_pkg.sv
// Shared MIPS32 decode constants, functional-unit ids, exception codes and the
// decoded-instruction record passed from the classifier to the stage register.
package decode_stage_pkg;

    localparam int OP_W  = 12;
    localparam int REG_W = 6;
    localparam int IMM_W = 32;
    localparam int EXC_W = 3;

    localparam logic [REG_W-1:0] REG_RA   = 6'd31;
    localparam logic [REG_W-1:0] REG_HILO = 6'd32;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F, OP_COP0   = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24, OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL   = 6'h02, FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04, FN_SRLV  = 6'h06, FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08, FN_JALR  = 6'h09, FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK = 6'h0D, FN_MFHI  = 6'h10, FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12, FN_MTLO  = 6'h13, FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV   = 6'h1A, FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20, FN_ADDU  = 6'h21, FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23, FN_AND   = 6'h24, FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26, FN_NOR   = 6'h27, FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // REGIMM rt codes and COP0 rs codes
    localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
    localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04;
    localparam logic [31:0] INST_ERET = 32'h4200_0018;

    // out_op = {code space, 6-bit opcode/funct/rt, one-hot group}
    localparam logic [3:0] OPG_ALU = 4'b0001, OPG_HILO = 4'b0010, OPG_MEM = 4'b0100, OPG_BR = 4'b1000;
    localparam logic [1:0] SP_SPECIAL = 2'd0, SP_IMM = 2'd1, SP_REGIMM = 2'd2, SP_COP0 = 2'd3;

    // Non-ALU unit ids sit directly above the ALU ids
    localparam int FU_BRU_OFS  = 0;
    localparam int FU_LSU_OFS  = 1;
    localparam int FU_HILO_OFS = 2;

    typedef enum logic [1:0] {FU_K_ALU, FU_K_BRU, FU_K_LSU, FU_K_HILO} fu_kind_e;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE    = 3'd0,
        EXC_SYSCALL = 3'd1,
        EXC_BREAK   = 3'd2,
        EXC_ERET    = 3'd3,
        EXC_RI      = 3'd4
    } exc_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] reg1;
        logic [REG_W-1:0] reg2;
        logic [REG_W-1:0] reg3;
        logic             r1_val;
        logic             r2_val;
        logic             rf_we;
        logic [IMM_W-1:0] imm;
        logic             sel_src1;
        logic             sel_src2;
        exc_e             exc;
    } dec_info_t;

    function automatic logic [REG_W-1:0] gpr(input logic [4:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/decode_stage_inst_classify.sv
// Purely combinational MIPS32 instruction classifier: operand/destination
// selection, immediate extension, unit kind and exception code.
module inst_classify
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [3:0]  pc_hi,
    output dec_info_t   info,
    output fu_kind_e    fu_kind,
    output logic        alu_class
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [31:0] imm_sa, imm_sx, imm_zx, imm_br, imm_j;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign sa     = inst[10:6];
    assign funct  = inst[5:0];

    assign imm_sa = {27'd0, sa};
    assign imm_sx = {{16{inst[15]}}, inst[15:0]};
    assign imm_zx = {16'd0, inst[15:0]};
    assign imm_br = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign imm_j  = {pc_hi, inst[25:0], 2'b00};

    dec_info_t d;
    fu_kind_e  kind;
    exc_e      exc;
    logic      ri;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        d    = '0;
        kind = FU_K_LSU;
        exc  = EXC_NONE;
        ri   = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                d.op[11:4] = {SP_SPECIAL, funct};
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ri = (rs != 5'd0);
                        kind = FU_K_ALU; d.op[3:0] = OPG_ALU;
                        d.reg2 = gpr(rt); d.r2_val = 1'b1;
                        d.imm = imm_sa; d.sel_src1 = 1'b1;
                        d.reg3 = gpr(rd); d.rf_we = 1'b1;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        ri = (sa != 5'd0);
                        kind = FU_K_ALU; d.op[3:0] = OPG_ALU;
                        d.reg1 = gpr(rs); d.r1_val = 1'b1;
                        d.reg2 = gpr(rt); d.r2_val = 1'b1;
                        d.reg3 = gpr(rd); d.rf_we = 1'b1;
                    end
                    FN_JR: begin
                        ri = ({rt, rd, sa} != 15'd0);
                        kind = FU_K_BRU; d.op[3:0] = OPG_BR;
                        d.reg1 = gpr(rs); d.r1_val = 1'b1;
                    end
                    FN_JALR: begin
                        ri = ({rt, sa} != 10'd0);
                        kind = FU_K_BRU; d.op[3:0] = OPG_BR;
                        d.reg1 = gpr(rs); d.r1_val = 1'b1;
                        d.reg3 = gpr(rd); d.rf_we = 1'b1;
                    end
                    FN_SYSCALL: exc = EXC_SYSCALL;
                    FN_BREAK:   exc = EXC_BREAK;
                    FN_MFHI, FN_MFLO: begin
                        ri = ({rs, rt, sa} != 15'd0);
                        kind = FU_K_HILO; d.op[3:0] = OPG_HILO;
                        d.reg1 = REG_HILO; d.r1_val = 1'b1;
                        d.reg3 = gpr(rd); d.rf_we = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        ri = ({rt, rd, sa} != 15'd0);
                        kind = FU_K_HILO; d.op[3:0] = OPG_HILO;
                        d.reg1 = gpr(rs); d.r1_val = 1'b1;
                        d.reg3 = REG_HILO; d.rf_we = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ri = ({rd, sa} != 10'd0);
                        kind = FU_K_HILO; d.op[3:0] = OPG_HILO;
                        d.reg1 = gpr(rs); d.r1_val = 1'b1;
                        d.reg2 = gpr(rt); d.r2_val = 1'b1;
                        d.reg3 = REG_HILO; d.rf_we = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                d.op = {SP_REGIMM, 1'b0, rt, OPG_BR};
                kind = FU_K_BRU;
                d.reg1 = gpr(rs); d.r1_val = 1'b1; d.imm = imm_br;
                case (rt)
                    RT_BLTZ, RT_BGEZ: ;
                    RT_BLTZAL, RT_BGEZAL: begin
                        d.reg3 = REG_RA; d.rf_we = 1'b1;
                    end
                    default: ri = 1'b1;
                endcase
            end
            OP_J, OP_JAL: begin
                d.op = {SP_IMM, opcode, OPG_BR};
                kind = FU_K_BRU; d.imm = imm_j;
                if (opcode == OP_JAL) begin
                    d.reg3 = REG_RA; d.rf_we = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                d.op = {SP_IMM, opcode, OPG_BR};
                kind = FU_K_BRU; d.imm = imm_br;
                d.reg1 = gpr(rs); d.r1_val = 1'b1;
                if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    d.reg2 = gpr(rt); d.r2_val = 1'b1;
                end else begin
                    ri = (rt != 5'd0);
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d.op = {SP_IMM, opcode, OPG_ALU};
                kind = FU_K_ALU;
                d.sel_src2 = 1'b1;
                d.reg3 = gpr(rt); d.rf_we = 1'b1;
                d.imm = (opcode inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI}) ? imm_zx : imm_sx;
                // lui ignores rs; the field must be zero
                if (opcode == OP_LUI) begin
                    ri = (rs != 5'd0);
                end else begin
                    d.reg1 = gpr(rs); d.r1_val = 1'b1;
                end
            end
            OP_COP0: begin
                d.op = {SP_COP0, 1'b0, rs, OPG_MEM};
                d.imm = {27'd0, rd};
                if (inst == INST_ERET) begin
                    exc = EXC_ERET;
                end else if (rs == RS_MFC0 && inst[10:3] == 8'd0) begin
                    d.reg3 = gpr(rt); d.rf_we = 1'b1;
                end else if (rs == RS_MTC0 && inst[10:3] == 8'd0) begin
                    d.reg1 = gpr(rt); d.r1_val = 1'b1;
                end else begin
                    ri = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                d.op = {SP_IMM, opcode, OPG_MEM};
                d.reg1 = gpr(rs); d.r1_val = 1'b1;
                d.imm = imm_sx; d.sel_src2 = 1'b1;
                d.reg3 = gpr(rt); d.rf_we = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                // Source 2 carries the store data; the offset travels in imm
                d.op = {SP_IMM, opcode, OPG_MEM};
                d.reg1 = gpr(rs); d.r1_val = 1'b1;
                d.reg2 = gpr(rt); d.r2_val = 1'b1;
                d.imm = imm_sx;
            end
            default: ri = 1'b1;
        endcase

        if (ri) exc = EXC_RI;
        if (exc != EXC_NONE) begin
            d    = '0;
            kind = FU_K_LSU;
        end
        d.exc = exc;
    end

    assign info      = d;
    assign fu_kind   = kind;
    assign alu_class = (kind == FU_K_ALU);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register, flush, and round-robin
// steering of ALU-class instructions across NUM_ALU units, skipping busy ones.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter  int NUM_ALU = 4,
    parameter  int RR_INIT = 0,
    localparam int FU_W    = $clog2(NUM_ALU + 3)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc,
    input  logic [31:0]        in_inst,
    input  logic [NUM_ALU-1:0] alu_busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [OP_W-1:0]    out_op,
    output logic [FU_W-1:0]    out_fu,
    output logic [REG_W-1:0]   out_reg1,
    output logic [REG_W-1:0]   out_reg2,
    output logic [REG_W-1:0]   out_reg3,
    output logic               out_r1_val,
    output logic               out_r2_val,
    output logic               out_rf_we,
    output logic [IMM_W-1:0]   out_imm,
    output logic               out_sel_src1,
    output logic               out_sel_src2,
    output logic [EXC_W-1:0]   out_exc
);

    localparam int PTR_W = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(RR_INIT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ALU - 1);

    dec_info_t        dec, q;
    fu_kind_e         kind;
    logic             alu_class;
    logic             accept;
    logic [PTR_W-1:0] rr_ptr, pick, rr_next, hi_pick, lo_pick;
    logic             hi_found, lo_found;
    logic [FU_W-1:0]  fu_d;

    inst_classify u_classify (
        .inst      (in_inst),
        .pc_hi     (in_pc[31:28]),
        .info      (dec),
        .fu_kind   (kind),
        .alu_class (alu_class)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;

    // Lowest free unit at or above rr_ptr wins; otherwise wrap to the lowest free unit.
    always_comb begin
        hi_pick  = rr_ptr;
        lo_pick  = rr_ptr;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = NUM_ALU - 1; i >= 0; i--) begin
            if (!alu_busy[i]) begin
                if (PTR_W'(i) >= rr_ptr) begin
                    hi_pick  = PTR_W'(i);
                    hi_found = 1'b1;
                end
                lo_pick  = PTR_W'(i);
                lo_found = 1'b1;
            end
        end
        pick    = hi_found ? hi_pick : (lo_found ? lo_pick : rr_ptr);
        rr_next = (pick == PTR_LAST) ? '0 : pick + 1'b1;
    end

    always_comb begin
        case (kind)
            FU_K_ALU:  fu_d = FU_W'(pick);
            FU_K_BRU:  fu_d = FU_W'(NUM_ALU + FU_BRU_OFS);
            FU_K_HILO: fu_d = FU_W'(NUM_ALU + FU_HILO_OFS);
            default:   fu_d = FU_W'(NUM_ALU + FU_LSU_OFS);
        endcase
    end

    // NOTE: reset is synchronous, so it sits inside the clocked block with no edge on resetn.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            q         <= '0;
            out_pc    <= '0;
            out_fu    <= '0;
            rr_ptr    <= PTR_INIT;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && in_pc != 32'd0) begin
            out_valid <= 1'b1;
            q         <= dec;
            out_pc    <= in_pc;
            out_fu    <= fu_d;
            if (alu_class) rr_ptr <= rr_next;
        end else if (out_ready) begin
            // Consumed (or a pc==0 bubble accepted): fields hold, valid drops
            out_valid <= 1'b0;
        end
    end

    assign out_op       = q.op;
    assign out_reg1     = q.reg1;
    assign out_reg2     = q.reg2;
    assign out_reg3     = q.reg3;
    assign out_r1_val   = q.r1_val;
    assign out_r2_val   = q.r2_val;
    assign out_rf_we    = q.rf_we;
    assign out_imm      = q.imm;
    assign out_sel_src1 = q.sel_src1;
    assign out_sel_src2 = q.sel_src2;
    assign out_exc      = q.exc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with NUM_ALU=4: decode fields, steering,
// backpressure, exceptions, flush and reset-during-stall.
module tb_decode_stage;

    localparam int NUM_ALU = 4;
    localparam logic [31:0] ADDU_321 = 32'h0022_1821;
    localparam logic [31:0] ADDU_534 = 32'h0064_2821;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_pc = '0;
    logic [31:0]        in_inst = '0;
    logic [NUM_ALU-1:0] alu_busy = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_pc;
    logic [11:0]        out_op;
    logic [2:0]         out_fu;
    logic [5:0]         out_reg1, out_reg2, out_reg3;
    logic               out_r1_val, out_r2_val, out_rf_we;
    logic [31:0]        out_imm;
    logic               out_sel_src1, out_sel_src2;
    logic [2:0]         out_exc;

    int n_vec = 0;
    int n_bad = 0;

    decode_stage #(.NUM_ALU(NUM_ALU), .RR_INIT(0)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .alu_busy(alu_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op(out_op), .out_fu(out_fu),
        .out_reg1(out_reg1), .out_reg2(out_reg2), .out_reg3(out_reg3),
        .out_r1_val(out_r1_val), .out_r2_val(out_r2_val), .out_rf_we(out_rf_we),
        .out_imm(out_imm), .out_sel_src1(out_sel_src1), .out_sel_src2(out_sel_src2),
        .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_fu", out_fu, 0);
        check("rst_imm", out_imm, 0);
        check("rst_pc", out_pc, 0);
        check("rst_in_ready", in_ready, 1);

        // Basic ALU decode (ptr 0 -> 1)
        send(32'hBFC0_0000, ADDU_321);
        check("addu_valid", out_valid, 1);
        check("addu_pc", out_pc, 32'hBFC0_0000);
        check("addu_reg1", out_reg1, 1);
        check("addu_reg2", out_reg2, 2);
        check("addu_reg3", out_reg3, 3);
        check("addu_we_vals", {out_rf_we, out_r1_val, out_r2_val}, 3'b111);
        check("addu_fu", out_fu, 0);
        check("addu_exc", out_exc, 0);
        check("addu_op", out_op, 12'h211);

        // ori zero-extends (ptr 1 -> 2)
        send(32'hBFC0_0004, 32'h3404_8000);
        check("ori_imm", out_imm, 32'h0000_8000);
        check("ori_sel_src2", out_sel_src2, 1);
        check("ori_reg3", out_reg3, 4);
        check("ori_r2_val", out_r2_val, 0);
        check("ori_fu", out_fu, 1);

        send(32'hBFC0_0008, 32'h8C85_0004);
        check("lw_fu", out_fu, NUM_ALU + 1);
        check("lw_imm", out_imm, 32'h0000_0004);
        check("lw_reg3", out_reg3, 5);
        check("lw_reg1", out_reg1, 4);

        // addiu sign-extends (ptr 2 -> 3)
        send(32'hBFC0_000C, 32'h2402_FFFF);
        check("addiu_imm", out_imm, 32'hFFFF_FFFF);
        check("addiu_fu", out_fu, 2);

        send(32'hBFC0_0010, 32'h1022_0003);
        check("beq_imm", out_imm, 32'h0000_000C);
        check("beq_fu", out_fu, NUM_ALU);
        check("beq_vals", {out_r1_val, out_r2_val, out_rf_we}, 3'b110);

        send(32'hBFC0_0020, 32'h0800_0010);
        check("j_imm", out_imm, 32'hB000_0040);
        check("j_rf_we", out_rf_we, 0);

        send(32'hBFC0_0024, 32'h0C00_0010);
        check("jal_reg3", out_reg3, 31);
        check("jal_rf_we", out_rf_we, 1);

        send(32'hBFC0_0028, 32'h0022_0018);
        check("mult_reg3", out_reg3, 32);
        check("mult_fu", out_fu, NUM_ALU + 2);

        send(32'hBFC0_002C, 32'h0000_1810);
        check("mfhi_reg1", out_reg1, 32);
        check("mfhi_reg3", out_reg3, 3);

        // Exceptions
        send(32'hBFC0_0030, 32'hFC00_0000);
        check("ri_exc", out_exc, 4);
        check("ri_rf_we", out_rf_we, 0);
        check("ri_fu", out_fu, NUM_ALU + 1);
        send(32'hBFC0_0034, 32'h0000_000C);
        check("syscall_exc", out_exc, 1);
        send(32'hBFC0_0038, 32'h0000_000D);
        check("break_exc", out_exc, 2);
        send(32'hBFC0_003C, 32'h4200_0018);
        check("eret_exc", out_exc, 3);
        check("eret_vals", {out_r1_val, out_r2_val, out_rf_we}, 3'b000);
        send(32'hBFC0_0040, 32'h0022_1861);
        check("addu_sa_exc", out_exc, 4);

        // NOP is sll, ALU class (ptr 3 -> 0)
        send(32'hBFC0_0044, 32'h0000_0000);
        check("nop_exc", out_exc, 0);
        check("nop_fu", out_fu, 3);

        send(32'h0000_0000, ADDU_321);
        check("bubble_valid", out_valid, 0);

        // Steering around busy unit 1
        do_reset();
        alu_busy = 4'b0010;
        send(32'h0000_0100, ADDU_321);
        check("rr_a", out_fu, 0);
        send(32'h0000_0104, ADDU_321);
        check("rr_b", out_fu, 2);
        send(32'h0000_0108, ADDU_321);
        check("rr_c", out_fu, 3);
        send(32'h0000_010C, ADDU_321);
        check("rr_d", out_fu, 0);
        alu_busy = 4'b1111;
        send(32'h0000_0110, ADDU_321);
        check("rr_allbusy", out_fu, 1);
        send(32'h0000_0114, ADDU_321);
        check("rr_allbusy_ptr", out_fu, 2);
        alu_busy = '0;

        // Backpressure (ptr 3)
        send(32'h0000_0200, ADDU_321);
        check("bp_first_fu", out_fu, 3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h0000_0204;
        in_inst   = ADDU_534;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_pc", out_pc, 32'h0000_0200);
            check("bp_hold_reg3", out_reg3, 3);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_next_pc", out_pc, 32'h0000_0204);
        check("bp_next_reg3", out_reg3, 5);
        check("bp_next_fu", out_fu, 0);

        // Flush with a valid output and a valid input (ptr 1 stays)
        in_valid = 1'b1;
        in_pc    = 32'h0000_0300;
        in_inst  = ADDU_321;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_pc_held", out_pc, 32'h0000_0204);
        send(32'h0000_0304, ADDU_321);
        check("flush_ptr_kept", out_fu, 1);

        // Reset during a stall (ptr 2 -> 3, then back to 0)
        send(32'h0000_0400, ADDU_321);
        check("stall_fu", out_fu, 2);
        out_ready = 1'b0;
        step();
        check("stall_valid", out_valid, 1);
        do_reset();
        check("stall_rst_valid", out_valid, 0);
        check("stall_rst_pc", out_pc, 0);
        out_ready = 1'b1;
        send(32'h0000_0404, ADDU_321);
        check("stall_rst_ptr", out_fu, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
